// File: rtl/game_pkg.sv
// Shared definitions for the game-flow controller: FSM states and the
// game_status codes that the video and audio overlays decode.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PLAY,
    LEVEL_WIN,
    WORLD_WIN,
    LIFE_LOST,
    GAME_WIN,
    GAME_OVER
  } state_t;

  localparam logic [2:0] ST_PLAYING   = 3'd0;
  localparam logic [2:0] ST_LEVEL_WIN = 3'd1;
  localparam logic [2:0] ST_WORLD_WIN = 3'd2;
  localparam logic [2:0] ST_GAME_WIN  = 3'd3;
  localparam logic [2:0] ST_GAME_OVER = 3'd4;
  localparam logic [2:0] ST_LIFE_LOST = 3'd5;
  localparam logic [2:0] ST_IDLE      = 3'd7;

  function automatic logic [2:0] status_of(input state_t s);
    case (s)
      PLAY:      return ST_PLAYING;
      LEVEL_WIN: return ST_LEVEL_WIN;
      WORLD_WIN: return ST_WORLD_WIN;
      LIFE_LOST: return ST_LIFE_LOST;
      GAME_WIN:  return ST_GAME_WIN;
      GAME_OVER: return ST_GAME_OVER;
      default:   return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Game-tick divider: counts enabled cycles 0..DIV-1 and raises tick for the
// cycle in which the count wraps. clr restarts the phase.
module tick_gen #(
  parameter int DIV = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt;
  logic          at_end;

  assign at_end = (cnt == CW'(DIV - 1));
  assign tick   = en && at_end;

  // NOTE: reset is sampled synchronously inside the clocked block, and all
  // state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= at_end ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Game-flow controller: level/world/lives tracking, timed status holds and
// level_load pulses. Level countdown is enabled by defining GAME_TIMER_EN.
module game_sequencer
  import game_pkg::*;
#(
  parameter  int NUM_LEVELS = 8,
  parameter  int NUM_WORLDS = 2,
  parameter  int LIVES      = 3,
  parameter  int TICK_DIV   = 100_000_000,
  parameter  int LEVEL_TIME = 60,
  parameter  int HOLD_TICKS = 3,
  localparam int LW = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
  localparam int WW = (NUM_WORLDS > 1) ? $clog2(NUM_WORLDS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          pause,
  input  logic          level_passed,
  input  logic          lose,
  output logic [LW-1:0] level,
  output logic [WW-1:0] world,
  output logic [3:0]    lives_left,
  output logic [7:0]    time_left,
  output logic [2:0]    game_status,
  output logic          playing,
  output logic          level_load
);

  localparam int HW = $clog2(HOLD_TICKS + 1);
`ifdef GAME_TIMER_EN
  localparam logic [7:0] TIME_INIT = 8'(LEVEL_TIME);
`else
  localparam logic [7:0] TIME_INIT = 8'(LEVEL_TIME * 0);
`endif

  state_t        state, state_n;
  logic [LW-1:0] level_n;
  logic [WW-1:0] world_n;
  logic [3:0]    lives_n;
  logic [7:0]    time_n;
  logic [HW-1:0] hold_r, hold_n;
  logic          tick, tick_en, expire, hold_done, last_level, last_world;

  // The divider runs during PLAY (unless paused) and the transient hold states.
  assign tick_en = ((state == PLAY) && !pause) || (state == LEVEL_WIN) ||
                   (state == WORLD_WIN) || (state == LIFE_LOST);

  tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (tick_en),
    .clr  (state_n != state),
    .tick (tick)
  );

`ifdef GAME_TIMER_EN
  assign expire = tick && (time_left == 8'd1);
`else
  assign expire = 1'b0;
`endif

  assign hold_done  = tick && (hold_r == HW'(HOLD_TICKS - 1));
  assign last_level = (level == LW'(NUM_LEVELS - 1));
  assign last_world = (world == WW'(NUM_WORLDS - 1));

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_n = state;
    level_n = level;
    world_n = world;
    lives_n = lives_left;
    time_n  = time_left;
    case (state)
      IDLE, GAME_WIN, GAME_OVER: begin
        if (start) begin
          state_n = PLAY;
          level_n = '0;
          world_n = '0;
          lives_n = 4'(LIVES);
          time_n  = TIME_INIT;
        end
      end
      PLAY: begin
        if (!pause) begin
          if (lose || expire) begin
            if (lives_left <= 4'd1) begin
              state_n = GAME_OVER;
              lives_n = '0;
            end else begin
              state_n = LIFE_LOST;
              lives_n = lives_left - 1'b1;
            end
          end else if (level_passed) begin
            if (!last_level)     state_n = LEVEL_WIN;
            else if (last_world) state_n = GAME_WIN;
            else                 state_n = WORLD_WIN;
          end else if (tick) begin
`ifdef GAME_TIMER_EN
            time_n = time_left - 1'b1;
`endif
          end
        end
      end
      LEVEL_WIN: begin
        if (hold_done) begin
          state_n = PLAY;
          level_n = level + 1'b1;
          time_n  = TIME_INIT;
        end
      end
      WORLD_WIN: begin
        if (hold_done) begin
          state_n = PLAY;
          level_n = '0;
          world_n = world + 1'b1;
          time_n  = TIME_INIT;
        end
      end
      LIFE_LOST: begin
        if (hold_done) begin
          state_n = PLAY;
          time_n  = TIME_INIT;
        end
      end
      default: state_n = IDLE;
    endcase

    // Hold ticks count from zero in every newly entered state.
    if (state_n != state) hold_n = '0;
    else if (tick)        hold_n = hold_r + 1'b1;
    else                  hold_n = hold_r;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      level       <= '0;
      world       <= '0;
      lives_left  <= 4'(LIVES);
      time_left   <= TIME_INIT;
      hold_r      <= '0;
      game_status <= ST_IDLE;
      playing     <= 1'b0;
      level_load  <= 1'b0;
    end else begin
      state       <= state_n;
      level       <= level_n;
      world       <= world_n;
      lives_left  <= lives_n;
      time_left   <= time_n;
      hold_r      <= hold_n;
      game_status <= status_of(state_n);
      playing     <= (state_n == PLAY) && !pause;
      level_load  <= (state_n == PLAY) && (state != PLAY);
    end
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: a cycle-level reference model of the
// game rules predicts every output; a monitor compares on the opposite edge.
module tb_game_sequencer;

  localparam int NL = 2, NW = 2, NLIVES = 2, DIV = 4, LTIME = 5, HOLD = 2;
`ifdef GAME_TIMER_EN
  localparam bit TIMER_ON = 1'b1;
`else
  localparam bit TIMER_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, pause = 1'b0, level_passed = 1'b0, lose = 1'b0;
  logic [0:0] level, world;
  logic [3:0] lives_left;
  logic [7:0] time_left;
  logic [2:0] game_status;
  logic       playing, level_load;

  game_sequencer #(
    .NUM_LEVELS(NL), .NUM_WORLDS(NW), .LIVES(NLIVES),
    .TICK_DIV(DIV), .LEVEL_TIME(LTIME), .HOLD_TICKS(HOLD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause),
    .level_passed(level_passed), .lose(lose),
    .level(level), .world(world), .lives_left(lives_left),
    .time_left(time_left), .game_status(game_status),
    .playing(playing), .level_load(level_load)
  );

  always #5 clk = ~clk;

  typedef struct {
    int status, level, world, lives, time_left, playing, load;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: status code stands for the game phase; m_phase counts
  // active cycles spent in the current phase.
  int m_status = 7, m_level = 0, m_world = 0, m_lives = NLIVES;
  int m_time = TIMER_ON ? LTIME : 0;
  int m_phase = 0, m_load = 0;
  bit m_tick, m_expire;

  function automatic void enter_play();
    m_status = 0;
    m_phase  = 0;
    m_time   = TIMER_ON ? LTIME : 0;
    m_load   = 1;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    m_load = 0;
    if (!rst) begin
      m_status = 7; m_level = 0; m_world = 0; m_lives = NLIVES;
      m_time = TIMER_ON ? LTIME : 0; m_phase = 0;
    end else begin
      case (m_status)
        7, 3, 4: if (start) begin
          m_level = 0; m_world = 0; m_lives = NLIVES;
          enter_play();
        end
        0: if (!pause) begin
          m_tick   = (m_phase % DIV) == DIV - 1;
          m_expire = TIMER_ON && m_tick && (m_time == 1);
          if (lose || m_expire) begin
            m_lives = m_lives - 1;
            m_status = (m_lives == 0) ? 4 : 5;
            m_phase = 0;
          end else if (level_passed) begin
            m_phase = 0;
            if (m_level != NL - 1)      m_status = 1;
            else if (m_world != NW - 1) m_status = 2;
            else                        m_status = 3;
          end else begin
            m_phase = m_phase + 1;
            if (TIMER_ON) m_time = LTIME - m_phase / DIV;
          end
        end
        default: begin
          if (m_phase == HOLD * DIV - 1) begin
            if (m_status == 1) m_level = m_level + 1;
            if (m_status == 2) begin m_level = 0; m_world = m_world + 1; end
            enter_play();
          end else begin
            m_phase = m_phase + 1;
          end
        end
      endcase
    end
    e.status    = m_status;
    e.level     = m_level;
    e.world     = m_world;
    e.lives     = m_lives;
    e.time_left = m_time;
    e.playing   = (m_status == 0 && !pause) ? 1 : 0;
    e.load      = m_load;
    exp_q.push_back(e);
  end

  task automatic check(input string name, input logic [7:0] act, input int exp_v);
    checks++;
    if (act !== 8'(exp_v)) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp_v);
    end
  endtask

  initial begin
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty at %0t: got 0 entries, expected 1", $time);
      end else begin
        e = exp_q.pop_front();
        check("game_status", 8'(game_status), e.status);
        check("level",       8'(level),       e.level);
        check("world",       8'(world),       e.world);
        check("lives_left",  8'(lives_left),  e.lives);
        check("time_left",   time_left,       e.time_left);
        check("playing",     8'(playing),     e.playing);
        check("level_load",  8'(level_load),  e.load);
      end
    end
  end

  task automatic drive(input bit s, input bit p, input bit lp, input bit lo, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = s; pause = p; level_passed = lp; lose = lo;
    end
    @(negedge clk);
    start = 0; pause = 0; level_passed = 0; lose = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 0;
    idle(2);
    rst = 1;
    idle(2);
    drive(1, 0, 0, 0, 1);   // start
    idle(3);
    drive(0, 0, 1, 0, 1);   // level win
    idle(12);
    drive(0, 0, 1, 0, 1);   // world win
    idle(12);
    drive(0, 0, 1, 0, 1);
    idle(12);
    drive(0, 0, 1, 0, 1);   // game win
    idle(5);
    drive(1, 0, 0, 0, 1);   // restart
    idle(3);
    drive(0, 0, 0, 1, 1);   // life lost
    idle(12);
    drive(0, 0, 0, 1, 1);   // game over
    idle(3);
    drive(1, 0, 0, 0, 1);
    idle(25);               // timer expiry (when enabled)
    idle(10);
    drive(0, 1, 1, 1, 6);   // paused events ignored
    drive(0, 0, 1, 1, 1);   // lose beats level_passed
    idle(12);
    drive(0, 0, 1, 0, 1);
    idle(12);
    drive(0, 0, 1, 0, 1);   // into world win
    idle(3);
    @(negedge clk) rst = 0;
    @(negedge clk) rst = 1;
    idle(2);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst          = ($urandom_range(0, 299) != 0);
      start        = ($urandom_range(0, 3) == 0);
      pause        = ($urandom_range(0, 7) == 0);
      level_passed = ($urandom_range(0, 9) == 0);
      lose         = ($urandom_range(0, 19) == 0);
    end
    @(negedge clk);
    rst = 1; start = 0; pause = 0; level_passed = 0; lose = 0;
    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
